// File: rtl/output_gain.sv
// Output gain stage: ramps a Q2.14 gain toward a selected target and applies it
// to each sample with floor-shift and 16-bit saturation; one cycle of latency.
module output_gain #(
    parameter int unsigned RAMP_STEP = 64
) (
    input  logic               clk_48,
    input  logic               reset_n,
    input  logic        [2:0]  gain,
    input  logic               mute,
    input  logic signed [15:0] gainIn,
    output logic signed [15:0] gainOut,
    output logic               ramping,
    output logic               muted,
    output logic        [15:0] dbg_cur_o,
    output logic        [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        STEADY    = 2'd3
    } state_t;

    localparam logic [16:0] STEP17 = 17'(RAMP_STEP);

    state_t             state_q, state_d;
    logic        [15:0] cur_q, cur_d;
    logic        [15:0] target_d;
    logic signed [15:0] gain_out_q, gain_out_d;
    logic               ramping_q, ramping_d;
    logic               muted_q, muted_d;

    logic        [16:0] cur17, tgt17, up_sum, dn_floor;
    logic signed [32:0] gain_in_ext, cur_sext, prod_w, shr_w;

    // Target gain table; mute overrides the selection.
    always_comb begin
        target_d = 16'd0;
        if (!mute) begin
            case (gain)
                3'd0:    target_d = 16'd4096;
                3'd1:    target_d = 16'd8192;
                3'd2:    target_d = 16'd11585;
                3'd3:    target_d = 16'd16384;
                3'd4:    target_d = 16'd23170;
                3'd5:    target_d = 16'd32768;
                3'd6:    target_d = 16'd46341;
                default: target_d = 16'd57344;
            endcase
        end
    end

    // Ramp arithmetic is done at 17 bits so neither direction can wrap.
    assign cur17    = {1'b0, cur_q};
    assign tgt17    = {1'b0, target_d};
    assign up_sum   = cur17 + STEP17;
    assign dn_floor = tgt17 + STEP17;

    always_comb begin
        cur_d = cur_q;
        if (cur_q < target_d) begin
            if (up_sum > tgt17) cur_d = target_d;
            else                cur_d = up_sum[15:0];
        end else if (cur_q > target_d) begin
            if (cur17 < dn_floor) cur_d = target_d;
            else                  cur_d = cur_q - STEP17[15:0];
        end
    end

    always_comb begin
        state_d   = STEADY;
        ramping_d = 1'b0;
        muted_d   = 1'b0;
        if (cur_d < target_d) begin
            state_d   = RAMP_UP;
            ramping_d = 1'b1;
        end else if (cur_d > target_d) begin
            state_d   = RAMP_DOWN;
            ramping_d = 1'b1;
        end else if (target_d == 16'd0) begin
            state_d = MUTED;
            muted_d = 1'b1;
        end
    end

    // Signed sample times zero-extended gain; the product always fits 33 bits.
    assign gain_in_ext = {{17{gainIn[15]}}, gainIn};
    assign cur_sext    = {17'd0, cur_q};
    assign prod_w      = gain_in_ext * cur_sext;
    assign shr_w       = prod_w >>> 14;

    always_comb begin
        gain_out_d = shr_w[15:0];
        if (shr_w > 33'sd32767)       gain_out_d = 16'sh7FFF;
        else if (shr_w < -33'sd32768) gain_out_d = 16'sh8000;
    end

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= MUTED;
            cur_q      <= 16'd0;
            gain_out_q <= 16'sd0;
            ramping_q  <= 1'b0;
            muted_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            gain_out_q <= gain_out_d;
            ramping_q  <= ramping_d;
            muted_q    <= muted_d;
        end
    end

    assign gainOut     = gain_out_q;
    assign ramping     = ramping_q;
    assign muted       = muted_q;
    assign dbg_cur_o   = cur_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_output_gain.sv
// Randomized and directed bench for output_gain: an arithmetic reference model
// fills a scoreboard queue that a monitor drains on every clock.
module tb_output_gain;

    localparam int STEP = 64;

    logic               clk_48  = 1'b0;
    logic               reset_n = 1'b0;
    logic        [2:0]  gain    = 3'd0;
    logic               mute    = 1'b0;
    logic signed [15:0] gainIn  = 16'sd0;
    logic signed [15:0] gainOut;
    logic               ramping;
    logic               muted;
    logic        [15:0] dbg_cur;
    logic        [1:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_cur  = 0;
    logic [33:0] exp_q[$];

    output_gain #(.RAMP_STEP(STEP)) dut (
        .clk_48     (clk_48),
        .reset_n    (reset_n),
        .gain       (gain),
        .mute       (mute),
        .gainIn     (gainIn),
        .gainOut    (gainOut),
        .ramping    (ramping),
        .muted      (muted),
        .dbg_cur_o  (dbg_cur),
        .dbg_state_o(dbg_state)
    );

    always #5 clk_48 = ~clk_48;

    function automatic int target_of(int g, bit m);
        int tbl[8] = '{4096, 8192, 11585, 16384, 23170, 32768, 46341, 57344};
        if (m) return 0;
        return tbl[g];
    endfunction

    // Real-valued scaling x*c/16384 rounded toward minus infinity, then clamped.
    function automatic int scale(int x, int c);
        longint p, q;
        p = longint'(x) * longint'(c);
        if (p >= 0) q = p / 16384;
        else        q = -((-p + 16383) / 16384);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    function automatic int rand_in();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return -32768;
        if (r == 1) return 32767;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One sample period: drive inputs, push the model's expectation, cross the edge.
    task automatic tick(int g, bit m, int x);
        int t, nxt, out;
        gain   = 3'(g);
        mute   = m;
        gainIn = 16'(x);
        t      = target_of(g, m);
        out    = scale(x, m_cur);
        if (m_cur < t)      nxt = (m_cur + STEP > t) ? t : m_cur + STEP;
        else if (m_cur > t) nxt = (m_cur - STEP < t) ? t : m_cur - STEP;
        else                nxt = m_cur;
        m_cur = nxt;
        exp_q.push_back({nxt != t, (nxt == 0) && (t == 0), 16'(nxt), 16'(out)});
        @(posedge clk_48);
        #2;
    endtask

    initial begin : monitor
        logic [33:0] e;
        forever begin
            @(posedge clk_48);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_gainOut", int'(gainOut), int'($signed(e[15:0])));
                check("sb_cur", int'(dbg_cur), int'(e[31:16]));
                check("sb_muted", int'(muted), int'(e[32]));
                check("sb_ramping", int'(ramping), int'(e[33]));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin : driver
        int cnt;
        int prev;

        repeat (3) @(posedge clk_48);
        #2;
        check("rst_gainOut", int'(gainOut), 0);
        check("rst_muted", int'(muted), 1);
        check("rst_ramping", int'(ramping), 0);
        check("rst_cur", int'(dbg_cur), 0);
        reset_n = 1'b1;

        // Soft start to unity gain.
        for (int i = 1; i <= 260; i++) begin
            tick(3, 1'b0, 1000);
            if (i == 1) check("soft_first_out", int'(gainOut), 0);
            if (i == 256) begin
                check("soft_cur_256", int'(dbg_cur), 16384);
                check("soft_ramping_256", int'(ramping), 0);
            end
            if (i >= 257) check("soft_out_unity", int'(gainOut), 1000);
        end

        // Floor behaviour at gain 0.25.
        for (int i = 0; i < 200; i++) tick(0, 1'b0, rand_in());
        tick(0, 1'b0, -1);
        check("round_neg1", int'(gainOut), -1);
        tick(0, 1'b0, 1);
        check("round_pos1", int'(gainOut), 0);

        // Saturation at gain 3.5.
        for (int i = 0; i < 840; i++) tick(7, 1'b0, rand_in());
        tick(7, 1'b0, 20000);
        check("sat_pos", int'(gainOut), 32767);
        tick(7, 1'b0, -20000);
        check("sat_neg", int'(gainOut), -32768);
        tick(7, 1'b0, -32768);
        check("sat_min", int'(gainOut), -32768);

        // Mute reversal in the middle of a ramp-up.
        for (int i = 0; i < 900; i++) tick(7, 1'b1, rand_in());
        for (int i = 0; i < 128; i++) tick(3, 1'b0, rand_in());
        check("rev_cur_start", int'(dbg_cur), 8192);
        tick(3, 1'b1, rand_in());
        check("rev_cur_next", int'(dbg_cur), 8128);
        check("rev_ramping", int'(ramping), 1);
        for (int i = 0; i < 127; i++) tick(3, 1'b1, rand_in());
        check("rev_cur_zero", int'(dbg_cur), 0);
        check("rev_muted", int'(muted), 1);
        for (int i = 0; i < 4; i++) begin
            tick(3, 1'b1, rand_in());
            check("rev_out_zero", int'(gainOut), 0);
        end

        // Retarget downward from 2.0 to ~1.414.
        for (int i = 0; i < 520; i++) tick(5, 1'b0, rand_in());
        cnt  = 0;
        prev = int'(dbg_cur);
        while (int'(dbg_cur) != 23170 && cnt < 400) begin
            prev = int'(dbg_cur);
            tick(4, 1'b0, rand_in());
            cnt++;
            if (int'(dbg_cur) != 23170) check("retgt_ramping", int'(ramping), 1);
        end
        check("retgt_steps", cnt, 150);
        check("retgt_prev_cur", prev, 23232);
        check("retgt_final_cur", int'(dbg_cur), 23170);
        check("retgt_ramping_end", int'(ramping), 0);

        // Asynchronous reset while ramping down through ~12000.
        cnt = 0;
        while (int'(dbg_cur) > 12000 && cnt < 400) begin
            tick(0, 1'b0, rand_in());
            cnt++;
        end
        check("rstmid_ramping_before", int'(ramping), 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rstmid_gainOut", int'(gainOut), 0);
        check("rstmid_muted", int'(muted), 1);
        check("rstmid_ramping", int'(ramping), 0);
        check("rstmid_cur", int'(dbg_cur), 0);
        m_cur = 0;
        repeat (2) @(posedge clk_48);
        #2;
        reset_n = 1'b1;

        // Random segments of held gain/mute settings.
        for (int s = 0; s < 30; s++) begin
            int g, len;
            bit m;
            g   = $urandom_range(0, 7);
            m   = ($urandom_range(0, 4) == 0);
            len = $urandom_range(1, 300);
            for (int i = 0; i < len; i++) tick(g, m, rand_in());
        end

        check("queue_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
